pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Hazard and sequencing controller for the 5-stage RISC-V pipeline. It drives the stall and clear inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the EX-stage operand-forwarding muxes. It detects load-use and branch hazards and sequences multi-cycle data-memory waits, with a watchdog. It keeps stall and flush performance counters. It sits beside the datapath with no data path of its own: register indices and control bits in, control strobes out.

## Interface
- `WAIT_LIMIT`, default 16: maximum consecutive data-memory wait cycles before the error trap; must be ≥1.
- `CNT_W`, default 32: width of the performance counters.

Ports:
- `Clk`  in  1: the single clock; all state updates on the rising edge.
- `Rst`  in  1: synchronous, active-high reset.
- `Rs1D`, `Rs2D`  in  5 each: source register indices in ID.
- `Rs1E`, `Rs2E`, `RdE`  in  5 each: source and destination indices in EX.
- `LoadE`  in  1: the EX instruction is a load.
- `PCSrcE`  in  1: branch or jump taken, resolved in EX.
- `RdM`, `RegWriteM`  in  5 / 1: MEM destination index and write enable.
- `RdW`, `RegWriteW`  in  5 / 1: WB destination index and write enable.
- `MemReqM`, `MemReadyM`  in  1 / 1: data-memory request and ready.
- `StallF`, `StallD`, `StallE`, `StallM`  out  1 each: hold the PC, IF/ID, ID/EX and EX/MEM registers.
- `FlushD`, `FlushE`, `FlushW`  out  1 each: synchronous clear of IF/ID, ID/EX and MEM/WB.
- `ForwardAE`, `ForwardBE`  out  2 each: operand select. 00 = register file, 01 = WB result, 10 = MEM ALU result.
- `MemErr`  out  1: sticky watchdog error.
- `StallCnt`, `FlushCnt`  out  `CNT_W` each: performance counters.

## Operation
**Forwarding** (combinational, active in every state):
- `ForwardAE` = 10 if `RegWriteM && RdM!=0 && RdM==Rs1E`.
- Otherwise 01 if `RegWriteW && RdW!=0 && RdW==Rs1E`.
- Otherwise 00.
- When MEM and WB both match, MEM wins.
- `ForwardBE` follows the same rules using `Rs2E`.

**Hazard terms:**
- `lw` = `LoadE && RdE!=0 && (RdE==Rs1D || RdE==Rs2D)`.
- `mw` = `MemReqM && !MemReadyM`.

**FSM states: RUN, WAIT, ERR.**
- RUN:
  - If `mw`: all four stalls = 1, `FlushW`=1, `FlushD`=`FlushE`=0. Next state WAIT, wait counter = 1.
  - Else: `StallF`=`StallD` = `lw && !PCSrcE`, `StallE`=`StallM`=0, `FlushD` = `PCSrcE`, `FlushE` = `PCSrcE || lw`, `FlushW`=0.
- WAIT:
  - If `mw` and counter < `WAIT_LIMIT`: same outputs as RUN with `mw`; counter +1.
  - If `mw` and counter == `WAIT_LIMIT`: same outputs; next state ERR.
  - If `!mw`: behave exactly as RUN with `!mw` in this same cycle; next state RUN, counter cleared.
- ERR: all four stalls = 1, `FlushW`=1, `MemErr`=1. Leaves only through `Rst`.

**Rules:**
- A taken branch during a memory wait is deferred, not lost. EX is frozen, so `PCSrcE` stays asserted and the flush fires in the first cycle with `!mw`.
- Taken branch plus load-use in the same cycle: the branch wins. F is not stalled and D and E are flushed.

**Counters:**
- `StallCnt` +1 on each cycle with `StallF`=1.
- `FlushCnt` +1 on each cycle with `PCSrcE && FlushE`.
- Both wrap modulo 2^`CNT_W` and hold in ERR.

## Timing
- Forward, stall and flush outputs are combinational from inputs and the current state, so they take effect the same cycle.
- State, wait counter, `MemErr` and the performance counters are registered and update on the `Clk` edge.
- While `Rst`=1:
  - Stalls are 0.
  - `FlushD`=`FlushE`=`FlushW`=1.
  - Forward outputs are 00.
  - The next state is RUN, with wait counter 0, `MemErr`=0 and both counters 0.
- Reset takes priority over every other event, including a pending ERR and an in-progress wait.
- Load-use costs exactly 1 bubble. A taken branch costs exactly 2 squashed instructions.
- A memory wait of N cycles (`mw` high N consecutive cycles, N ≤ `WAIT_LIMIT`) produces N stall cycles. ERR is reached on the `WAIT_LIMIT`+1th consecutive `mw` cycle.

## Structure
- Shared package `pipe_pkg`:
  - FSM state enum (RUN, WAIT, ERR).
  - Forward select constants `FWD_RF`=00, `FWD_WB`=01, `FWD_MEM`=10.
- One natural sub-module, `fwd_unit`: the combinational forwarding comparator, instantiated twice (A and B).
- Everything else lives in `pipe_hazard_ctrl`.

## Test plan
- Back-to-back RAW: `RdM`=5 and `RdW`=5 with both writes set, `Rs1E`=5 → `ForwardAE`=10. Set `RegWriteM`=0 → 01. Set `RdM`=`RdW`=0 → 00.
- Load-use: `LoadE`=1, `RdE`=7, `Rs2D`=7 → `StallF`=`StallD`=`FlushE`=1 for 1 cycle, `StallCnt`=1. With `RdE`=0 → no stall.
- Taken branch together with load-use → `StallF`=0, `FlushD`=`FlushE`=1, `FlushCnt`=1.
- Memory wait of 3 cycles with `PCSrcE` held → 3 cycles of all stalls with `FlushW`=1 and no `FlushD`. The branch flush fires in the 4th cycle; state back to RUN.
- Watchdog, `WAIT_LIMIT`=4: `mw` held for 6 cycles → `MemErr`=1 from cycle 6 and stalls stay 1 after `MemReadyM` rises. `Rst` for 1 cycle → `MemErr`=0, state RUN, counters 0.
- Reset mid-wait (2nd `mw` cycle) → next cycle in RUN with wait counter 0. `FlushD`/`FlushE`/`FlushW`=1 during the reset cycle.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the sequencing FSM states, the forward selects and the match helper.
package pipe_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // x0 is hardwired zero, so a write to it never supplies a value
  function automatic logic rd_hit(
    input logic       we,
    input logic [4:0] rd,
    input logic [4:0] rs
  );
    return we && (rd != 5'd0) && (rd == rs);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_fwd.sv
// EX-stage operand forwarding comparator for one source operand.
// The younger MEM result takes precedence over the WB result.
module fwd_unit
  import pipe_pkg::*;
(
  input  logic [4:0] rs,
  input  logic [4:0] rdm,
  input  logic       regwritem,
  input  logic [4:0] rdw,
  input  logic       regwritew,
  output logic [1:0] sel
);

  always_comb begin
    sel = FWD_RF;
    if (rd_hit(regwritem, rdm, rs))
      sel = FWD_MEM;
    else if (rd_hit(regwritew, rdw, rs))
      sel = FWD_WB;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline.
// Drives stalls, flushes and forwarding; times data-memory waits.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int WAIT_LIMIT = 16,
  parameter int CNT_W      = 32
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic             LoadE,
  input  logic             PCSrcE,
  input  logic [4:0]       RdM,
  input  logic             RegWriteM,
  input  logic [4:0]       RdW,
  input  logic             RegWriteW,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             MemErr,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
);

  localparam int WCW = $clog2(WAIT_LIMIT + 1);

  state_t         state;
  logic [WCW-1:0] wcnt;
  logic           mem_err;
  logic           lw;
  logic           mw;
  logic           freeze;
  logic [1:0]     fwd_a;
  logic [1:0]     fwd_b;

  fwd_unit u_fwd_a (
    .rs        (Rs1E),
    .rdm       (RdM),
    .regwritem (RegWriteM),
    .rdw       (RdW),
    .regwritew (RegWriteW),
    .sel       (fwd_a)
  );

  fwd_unit u_fwd_b (
    .rs        (Rs2E),
    .rdm       (RdM),
    .regwritem (RegWriteM),
    .rdw       (RdW),
    .regwritew (RegWriteW),
    .sel       (fwd_b)
  );

  assign ForwardAE = Rst ? FWD_RF : fwd_a;
  assign ForwardBE = Rst ? FWD_RF : fwd_b;

  assign lw = LoadE && (RdE != 5'd0)
           && ((RdE == Rs1D) || (RdE == Rs2D));
  assign mw = MemReqM && !MemReadyM;

  // a stuck memory or the error trap freezes the whole pipe
  assign freeze = (state == ERR) || mw;

  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    unique case (1'b1)
      Rst: begin
        FlushD = 1'b1;
        FlushE = 1'b1;
        FlushW = 1'b1;
      end
      (!Rst && freeze): begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end
      (!Rst && !freeze): begin
        StallF = lw && !PCSrcE;
        StallD = lw && !PCSrcE;
        FlushD = PCSrcE;
        FlushE = PCSrcE || lw;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state   <= RUN;
      wcnt    <= '0;
      mem_err <= 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          if (mw) begin
            state <= WAIT;
            wcnt  <= WCW'(1);
          end
        end
        WAIT: begin
          if (!mw) begin
            state <= RUN;
            wcnt  <= '0;
          end else if (wcnt == WCW'(WAIT_LIMIT)) begin
            state   <= ERR;
            mem_err <= 1'b1;
          end else begin
            wcnt <= wcnt + WCW'(1);
          end
        end
        ERR: ;
        default: state <= RUN;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      StallCnt <= '0;
      FlushCnt <= '0;
    end else if (state != ERR) begin
      if (StallF)
        StallCnt <= StallCnt + CNT_W'(1);
      if (PCSrcE && FlushE)
        FlushCnt <= FlushCnt + CNT_W'(1);
    end
  end

  assign MemErr = mem_err;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl with a cycle-level reference
// model tracking consecutive wait length and a sticky error flag.
module tb_pipe_hazard_ctrl;

  localparam int WL = 4;
  localparam int CW = 32;

  logic          Clk = 1'b0;
  logic          Rst;
  logic [4:0]    Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic          LoadE, PCSrcE, RegWriteM, RegWriteW;
  logic          MemReqM, MemReadyM;
  logic          StallF, StallD, StallE, StallM;
  logic          FlushD, FlushE, FlushW;
  logic [1:0]    ForwardAE, ForwardBE;
  logic          MemErr;
  logic [CW-1:0] StallCnt, FlushCnt;

  pipe_hazard_ctrl #(.WAIT_LIMIT(WL), .CNT_W(CW)) dut (
    .Clk(Clk), .Rst(Rst),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .LoadE(LoadE), .PCSrcE(PCSrcE),
    .RdM(RdM), .RegWriteM(RegWriteM), .RdW(RdW), .RegWriteW(RegWriteW),
    .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .MemErr(MemErr), .StallCnt(StallCnt), .FlushCnt(FlushCnt)
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;

  bit            m_err;
  int            m_run;
  logic [CW-1:0] m_sc, m_fc;

  typedef struct {
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic       loade, pcsrce, rwm, rww;
    logic [1:0] fa, fb;
    logic       sf, fd, fe;
  } vec_t;

  vec_t vt[9];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] mfwd(input logic [4:0] rs);
    if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
    if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic clear_in();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    LoadE = 0; PCSrcE = 0; RegWriteM = 0; RegWriteW = 0;
    MemReqM = 0; MemReadyM = 1;
  endtask

  // compare every output with the model, then clock and advance the model
  task automatic go();
    logic mw, lw, sf, se, fd, fe, fw;
    logic [1:0] fa, fb;
    mw = MemReqM && !MemReadyM;
    lw = LoadE && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
    fa = mfwd(Rs1E);
    fb = mfwd(Rs2E);
    if (Rst) begin
      sf = 0; se = 0; fd = 1; fe = 1; fw = 1; fa = 0; fb = 0;
    end else if (m_err || mw) begin
      sf = 1; se = 1; fd = 0; fe = 0; fw = 1;
    end else begin
      sf = lw && !PCSrcE; se = 0; fd = PCSrcE; fe = PCSrcE || lw; fw = 0;
    end
    chk("StallF", StallF, sf);
    chk("StallD", StallD, sf);
    chk("StallE", StallE, se);
    chk("StallM", StallM, se);
    chk("FlushD", FlushD, fd);
    chk("FlushE", FlushE, fe);
    chk("FlushW", FlushW, fw);
    chk("ForwardAE", ForwardAE, fa);
    chk("ForwardBE", ForwardBE, fb);
    chk("MemErr", MemErr, m_err);
    chk("StallCnt", StallCnt, m_sc);
    chk("FlushCnt", FlushCnt, m_fc);
    @(posedge Clk);
    if (Rst) begin
      m_err = 0; m_run = 0; m_sc = 0; m_fc = 0;
    end else if (!m_err) begin
      if (sf) m_sc = m_sc + 1;
      if (PCSrcE && fe) m_fc = m_fc + 1;
      if (mw) begin
        m_run++;
        if (m_run > WL) m_err = 1;
      end else begin
        m_run = 0;
      end
    end
    @(negedge Clk);
  endtask

  task automatic step();
    #1;
    go();
  endtask

  task automatic do_reset();
    clear_in();
    Rst = 1;
    step();
    Rst = 0;
  endtask

  initial begin
    m_err = 0; m_run = 0; m_sc = '0; m_fc = '0;
    // rs1d rs2d rs1e rs2e rde rdm rdw ld br rwm rww fa fb sf fd fe
    vt[0] = '{0, 0, 5, 0, 0, 5, 5, 0, 0, 1, 1, 2'b10, 2'b00, 0, 0, 0};
    vt[1] = '{0, 0, 5, 0, 0, 5, 5, 0, 0, 0, 1, 2'b01, 2'b00, 0, 0, 0};
    vt[2] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2'b00, 2'b00, 0, 0, 0};
    vt[3] = '{0, 0, 3, 9, 0, 3, 9, 0, 0, 1, 1, 2'b10, 2'b01, 0, 0, 0};
    vt[4] = '{0, 7, 0, 0, 7, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 1, 0, 1};
    vt[5] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0};
    vt[6] = '{7, 0, 0, 0, 7, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 0, 1, 1};
    vt[7] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 0, 1, 1};
    vt[8] = '{7, 0, 4, 4, 7, 4, 4, 0, 0, 0, 1, 2'b01, 2'b01, 0, 0, 0};

    clear_in();
    Rst = 1;
    @(negedge Clk);
    step();
    Rst = 0;
    #1;
    chk("rst_MemErr", MemErr, 0);
    chk("rst_StallCnt", StallCnt, 0);
    chk("rst_FlushCnt", FlushCnt, 0);
    go();

    foreach (vt[i]) begin
      Rs1D = vt[i].rs1d; Rs2D = vt[i].rs2d; Rs1E = vt[i].rs1e;
      Rs2E = vt[i].rs2e; RdE = vt[i].rde; RdM = vt[i].rdm; RdW = vt[i].rdw;
      LoadE = vt[i].loade; PCSrcE = vt[i].pcsrce;
      RegWriteM = vt[i].rwm; RegWriteW = vt[i].rww;
      MemReqM = 0; MemReadyM = 1;
      #1;
      chk($sformatf("v%0d_fa", i), ForwardAE, vt[i].fa);
      chk($sformatf("v%0d_fb", i), ForwardBE, vt[i].fb);
      chk($sformatf("v%0d_sf", i), StallF, vt[i].sf);
      chk($sformatf("v%0d_fd", i), FlushD, vt[i].fd);
      chk($sformatf("v%0d_fe", i), FlushE, vt[i].fe);
      go();
    end

    // load-use costs one stall, then branch beats load-use
    do_reset();
    LoadE = 1; RdE = 7; Rs2D = 7;
    step();
    clear_in();
    #1;
    chk("lu_StallCnt", StallCnt, 1);
    chk("lu_StallF_after", StallF, 0);
    go();
    LoadE = 1; RdE = 7; Rs2D = 7; PCSrcE = 1;
    step();
    clear_in();
    #1;
    chk("br_FlushCnt", FlushCnt, 1);
    chk("br_StallCnt", StallCnt, 1);
    go();

    // 3-cycle wait with a deferred branch
    do_reset();
    MemReqM = 1; MemReadyM = 0; PCSrcE = 1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("mw_StallF", StallF, 1);
      chk("mw_StallM", StallM, 1);
      chk("mw_FlushW", FlushW, 1);
      chk("mw_FlushD", FlushD, 0);
      go();
    end
    MemReadyM = 1;
    #1;
    chk("mw_br_FlushD", FlushD, 1);
    chk("mw_br_StallF", StallF, 0);
    go();
    clear_in();
    #1;
    chk("mw_StallCnt", StallCnt, 3);
    chk("mw_FlushCnt", FlushCnt, 1);
    go();

    // watchdog trap and recovery by reset
    do_reset();
    MemReqM = 1; MemReadyM = 0;
    for (int c = 1; c <= 6; c++) begin
      #1;
      chk($sformatf("wd_MemErr_c%0d", c), MemErr, (c == 6));
      go();
    end
    MemReadyM = 1;
    #1;
    chk("err_StallF", StallF, 1);
    chk("err_MemErr", MemErr, 1);
    chk("err_StallCnt", StallCnt, WL + 1);
    go();
    Rst = 1;
    #1;
    chk("err_rst_FlushD", FlushD, 1);
    chk("err_rst_StallF", StallF, 0);
    go();
    Rst = 0; MemReqM = 0;
    #1;
    chk("rec_MemErr", MemErr, 0);
    chk("rec_StallCnt", StallCnt, 0);
    chk("rec_FlushCnt", FlushCnt, 0);
    chk("rec_StallF", StallF, 0);
    go();

    // reset on the second wait cycle restarts the wait count
    MemReqM = 1; MemReadyM = 0;
    step();
    Rst = 1;
    #1;
    chk("mr_FlushD", FlushD, 1);
    chk("mr_FlushE", FlushE, 1);
    chk("mr_FlushW", FlushW, 1);
    go();
    Rst = 0;
    for (int c = 0; c < WL; c++) step();
    #1;
    chk("mr_no_err", MemErr, 0);
    go();
    #1;
    chk("mr_err", MemErr, 1);
    go();

    // randomized traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      Rst = ($urandom_range(0, 63) == 0);
      Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
      Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
      RdE = 5'($urandom_range(0, 3));
      RdM = 5'($urandom_range(0, 3)); RdW = 5'($urandom_range(0, 3));
      LoadE = 1'($urandom); PCSrcE = 1'($urandom);
      RegWriteM = 1'($urandom); RegWriteW = 1'($urandom);
      MemReqM = ($urandom_range(0, 3) != 0);
      if ((i % 400) < 200)
        MemReadyM = ($urandom_range(0, 5) == 0);
      else
        MemReadyM = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
